// File: rtl/au_sched.sv
// au_sched: two-requester scheduler in front of a single arithmetic unit.
// Requests are round-robin arbitrated into a command FIFO, then issued one
// at a time to the AU as start levels. Each completion is returned on a
// response channel.
// Optional feature: define AU_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles. The aborted operation is answered with rsp_err=1.
//
// Handshake semantics (requests and response): a transfer happens on a
// rising clk edge where valid and ready are both high. The producer holds
// valid and payload stable until that transfer. reqN_ready never depends on
// reqN_valid of the same requester, except through the shared grant choice.
module au_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [7:0]  au_a,
  output logic [7:0]  au_b,
  output logic        au_startadd,
  output logic        au_startsub,
  output logic        au_startmultiplier,
  output logic        au_startdiv,
  input  logic [15:0] au_result,
  input  logic        au_done,
  input  logic [3:0]  au_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + 2 + 8 + 8;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, fifo_empty;
  logic               rr_ptr, grant, can_push, push, pop;
  logic [ENTRY_W-1:0] push_data;

  logic               opr_id;
  logic [1:0]         opr_op;
  logic [7:0]         opr_a, opr_b;
  logic               active, timeout, finish_op;

  assign full       = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  // Arbitration: a lone requester wins, contention goes to the round-robin pointer.
  always_comb begin
    grant = rr_ptr;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  // The FIFO accepts nothing while in reset or when full (no push/pop bypass).
  assign can_push   = rst && !full;
  assign req0_ready = can_push && !grant;
  assign req1_ready = can_push && grant;
  assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign push_data  = grant ? {1'b1, req1_op, req1_a, req1_b}
                            : {1'b0, req0_op, req0_a, req0_b};
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (push) rr_ptr <= ~rr_ptr;
    end
  end

  // FIFO storage; validity is tracked by count, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef AU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // WAIT-cycle counter, restarted for every issued operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state_q == S_ISSUE) begin
      to_cnt <= '0;
    end else if (state_q == S_WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state_q == S_WAIT) && (to_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // au_done wins over a timeout in the same cycle.
  assign finish_op = (state_q == S_WAIT) && (au_done || timeout);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (finish_op) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operation register (loaded on pop) and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opr_id     <= 1'b0;
      opr_op     <= 2'd0;
      opr_a      <= 8'd0;
      opr_b      <= 8'd0;
      rsp_id     <= 1'b0;
      rsp_result <= 16'd0;
      rsp_flags  <= 4'd0;
    end else begin
      if (pop) {opr_id, opr_op, opr_a, opr_b} <= mem[rd_ptr];
      if (finish_op) begin
        rsp_id     <= opr_id;
        rsp_result <= au_done ? au_result : 16'd0;
        rsp_flags  <= au_done ? au_flags : 4'd0;
      end
    end
  end

`ifdef AU_TIMEOUT_EN
  // Error flag marks a response produced by the timeout path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rsp_err <= 1'b0;
    else if (finish_op) rsp_err <= !au_done;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Start levels are held through ISSUE and WAIT only. RESP always gives at
  // least one low cycle between operations, so the AU sees a fresh rising edge.
  assign active             = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign au_startadd        = active && (opr_op == 2'd0);
  assign au_startsub        = active && (opr_op == 2'd1);
  assign au_startmultiplier = active && (opr_op == 2'd2);
  assign au_startdiv        = active && (opr_op == 2'd3);
  assign au_a               = opr_a;
  assign au_b               = opr_b;
  assign rsp_valid          = (state_q == S_RESP);
  assign busy               = (state_q != S_IDLE) || !fifo_empty;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_au_sched.sv
// tb_au_sched: directed vector table, corner-case sequences, and a
// randomized run against a queue-based reference of the scheduler.
module tb_au_sched;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [7:0]  au_a, au_b;
  logic        au_startadd, au_startsub, au_startmultiplier, au_startdiv;
  logic [15:0] au_result;
  logic        au_done;
  logic [3:0]  au_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  int outstanding = 0;
  int rsp_cnt = 0;
  bit m_ptr = 0;
  bit acc0 = 0, acc1 = 0;
  bit au_stall = 0, au_rand = 0;
  int au_lat_fix = 0;

  logic [3:0] starts;
  logic       start_any;
  logic [1:0] cur_op;
  assign starts    = {au_startadd, au_startsub, au_startmultiplier, au_startdiv};
  assign start_any = |starts;
  assign cur_op    = au_startdiv ? 2'd3 : au_startmultiplier ? 2'd2 : au_startsub ? 2'd1 : 2'd0;

  au_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .au_a(au_a), .au_b(au_b),
    .au_startadd(au_startadd), .au_startsub(au_startsub),
    .au_startmultiplier(au_startmultiplier), .au_startdiv(au_startdiv),
    .au_result(au_result), .au_done(au_done), .au_flags(au_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] au_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return {8'd0, a} + {8'd0, b};
      2'd1:    return {8'd0, a} - {8'd0, b};
      2'd2:    return {8'd0, a} * {8'd0, b};
      default: return (b == 8'd0) ? 16'hFFFF : {a / b, a % b};
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input logic [15:0] r);
    return {r[15] ^ r[14], r[15], r == 16'd0, r[8]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Behavioural AU: rising start edge launches an op, done after a latency.
  initial begin : au_model
    int cnt;
    bit pend, prev;
    logic [15:0] res;
    cnt = 0; pend = 0; prev = 0; res = '0;
    au_done = 1'b0; au_result = '0; au_flags = '0;
    forever begin
      @(posedge clk); #1;
      au_done = 1'b0;
      if (!rst) begin
        pend = 0; prev = 0;
      end else begin
        if (pend && start_any) begin
          if (cnt == 0) begin
            au_done = 1'b1; au_result = res; au_flags = flags_of(res); pend = 0;
          end else cnt--;
        end else if (!start_any && au_rand && $urandom_range(0, 7) == 0) begin
          au_done = 1'b1; au_result = 16'hDEAD; au_flags = 4'hF;
        end
        if (!start_any) pend = 0;
        if (start_any && !prev && !au_stall) begin
          pend = 1;
          cnt  = au_rand ? int'($urandom_range(0, 3)) : au_lat_fix;
          res  = au_fn(cur_op, au_a, au_b);
        end
        prev = start_any;
      end
    end
  end

  task automatic drive(input bit id, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // Called at negedge: records accepted requests, scores completed responses.
  task automatic observe();
    logic [15:0] r;
    logic [20:0] e;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0) begin
      r = au_fn(req0_op, req0_a, req0_b);
      exp_q.push_back({1'b0, r, flags_of(r)});
      outstanding++;
    end
    if (acc1) begin
      r = au_fn(req1_op, req1_a, req1_b);
      exp_q.push_back({1'b1, r, flags_of(r)});
      outstanding++;
    end
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      check("rsp_queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_fields", {rsp_id, rsp_result, rsp_flags, rsp_err}, {e, 1'b0});
      end
      outstanding--;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(0, 0, 2'd0, 8'd0, 8'd0);
    drive(1, 0, 2'd0, 8'd0, 8'd0);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    outstanding = 0; rsp_cnt = 0; m_ptr = 0; acc0 = 0; acc1 = 0;
  endtask

  typedef struct {
    bit          id;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] res;
  } vec_t;

  // One request on an idle block: latency, start pulse width, response fields.
  task automatic run_vec(input vec_t v);
    int n, st_exp, st_other;
    bit got, sel;
    au_lat_fix = v.lat;
    @(posedge clk); #1;
    drive(v.id, 1, v.op, v.a, v.b);
    @(negedge clk);
    check("vec_rsp_clear", rsp_valid, 0);
    check("vec_ready", v.id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    drive(v.id, 0, v.op, v.a, v.b);
    n = 0; st_exp = 0; st_other = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      sel = starts[3 - v.op];
      if (sel) st_exp++;
      if ($countones(starts) > int'(sel)) st_other++;
      if (rsp_valid) got = 1;
    end
    check("vec_latency", n, 4 + v.lat);
    check("vec_rsp", {rsp_id, rsp_result, rsp_flags, rsp_err},
          {v.id, v.res, flags_of(v.res), 1'b0});
    check("vec_start_cycles", st_exp, 2 + v.lat);
    check("vec_other_starts", st_other, 0);
  endtask

  task automatic seq_pair();
    int n, last_mul, first_div;
    apply_reset();
    rsp_ready = 1'b1; au_lat_fix = 1;
    @(posedge clk); #1;
    drive(0, 1, 2'd2, 8'h10, 8'h10);
    drive(1, 1, 2'd3, 8'h43, 8'h08);
    @(negedge clk);
    check("pair_first_grant", {req0_ready, req1_ready}, 2'b10);
    observe();
    @(posedge clk); #1;
    drive(0, 0, 2'd0, 8'd0, 8'd0);
    @(negedge clk);
    check("pair_second_grant", {req0_ready, req1_ready}, 2'b01);
    observe();
    @(posedge clk); #1;
    drive(1, 0, 2'd0, 8'd0, 8'd0);
    n = 0; last_mul = -100; first_div = -1;
    while (rsp_cnt < 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (au_startmultiplier) last_mul = n;
      if (au_startdiv && first_div < 0) first_div = n;
      observe();
    end
    check("pair_rsp_count", rsp_cnt, 2);
    check("pair_start_gap", (first_div - last_mul) >= 2, 1);
  endtask

  task automatic seq_full();
    int n_acc, n;
    apply_reset();
    au_lat_fix = 0; n_acc = 0;
    @(posedge clk); #1;
    drive(1, 1, 2'd0, 8'd0, 8'h10);
    repeat (30) begin
      @(negedge clk);
      observe();
      if (acc1) n_acc++;
      @(posedge clk); #1;
      if (acc1) drive(1, 1, 2'd0, 8'(n_acc), 8'h10);
    end
    @(negedge clk);
    check("full_accepts", n_acc, DEPTH + 1);
    check("full_ready_low", req1_ready, 0);
    check("full_busy", busy, 1);
    observe();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_cnt < DEPTH + 2 && n < 100) begin
      @(negedge clk);
      n++;
      observe();
      if (acc1) n_acc++;
      @(posedge clk); #1;
      if (acc1) drive(1, (n_acc < DEPTH + 2), 2'd0, 8'(n_acc), 8'h10);
    end
    check("full_rsp_count", rsp_cnt, DEPTH + 2);
    check("full_queue_empty", exp_q.size(), 0);
  endtask

  task automatic seq_rst_wait();
    int n, n_mul, seen;
    apply_reset();
    rsp_ready = 1'b1; au_lat_fix = 20;
    @(posedge clk); #1;
    drive(0, 1, 2'd2, 8'h12, 8'h34);
    drive(1, 1, 2'd0, 8'h01, 8'h02);
    n = 0; n_mul = 0;
    while (n_mul < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if (au_startmultiplier) n_mul++;
      observe();
      if (n_mul < 3) begin
        @(posedge clk); #1;
        if (acc0) drive(0, 0, 2'd0, 8'd0, 8'd0);
        if (acc1) drive(1, 0, 2'd0, 8'd0, 8'd0);
      end
    end
    check("rw_in_wait", n_mul, 3);
    #1 rst = 1'b0;
    #1;
    check("rw_starts_low", starts, 4'd0);
    check("rw_rsp_busy", {rsp_valid, busy, req0_ready, req1_ready}, 4'd0);
    check("rw_ops_zero", {au_a, au_b}, 16'd0);
    drive(0, 0, 2'd0, 8'd0, 8'd0);
    drive(1, 0, 2'd0, 8'd0, 8'd0);
    #1 rst = 1'b1;
    exp_q.delete(); outstanding = 0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rw_no_rsp", seen, 0);
    check("rw_idle", busy, 0);
  endtask

  task automatic seq_timeout();
    int n, n_start, seen;
    bit got;
    apply_reset();
    rsp_ready = 1'b1; au_stall = 1;
    @(posedge clk); #1;
    drive(0, 1, 2'd0, 8'h05, 8'h06);
    @(negedge clk);
    check("to_accept", req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 0, 2'd0, 8'd0, 8'd0);
    n = 0; n_start = 0; got = 0; seen = 0;
`ifdef AU_TIMEOUT_EN
    while (!got && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1;
      else if (start_any) n_start++;
    end
    check("to_start_cycles", n_start, TIMEOUT + 1);
    check("to_rsp", {rsp_valid, rsp_err, rsp_result, rsp_flags}, {1'b1, 1'b1, 16'h0, 4'h0});
`else
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_to_rsp", seen, 0);
    check("no_to_hold", {busy, au_startadd}, 2'b11);
`endif
    au_stall = 0;
  endtask

  task automatic seq_random();
    bit any_v, exp_g;
    int n;
    apply_reset();
    au_rand = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 99) < 45)
        drive(0, 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (!req1_valid && $urandom_range(0, 99) < 45)
        drive(1, 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      any_v = req0_valid || req1_valid;
      exp_g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      if (outstanding < DEPTH && any_v)
        check("rnd_ready", {req0_ready, req1_ready}, exp_g ? 2'b01 : 2'b10);
      else if (outstanding > DEPTH)
        check("rnd_full", {req0_ready, req1_ready}, 2'b00);
      else if (any_v && (req0_ready || req1_ready))
        check("rnd_grant", {req0_ready, req1_ready}, exp_g ? 2'b01 : 2'b10);
      check("rnd_start_onehot", $countones(starts) <= 1, 1);
      observe();
      if (acc0 || acc1) m_ptr = !m_ptr;
    end
    n = 0;
    while ((exp_q.size() != 0 || req0_valid || req1_valid) && n < 400) begin
      @(posedge clk); #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      n++;
      observe();
    end
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_activity", rsp_cnt > 100, 1);
    au_rand = 0;
  endtask

  initial begin : main
    vec_t vecs[8];
    vecs[0] = '{1'b0, 2'd0, 8'h30, 8'h12, 0, 16'h0042};
    vecs[1] = '{1'b1, 2'd1, 8'h10, 8'h20, 0, 16'hFFF0};
    vecs[2] = '{1'b0, 2'd2, 8'hFF, 8'hFF, 2, 16'hFE01};
    vecs[3] = '{1'b1, 2'd3, 8'h43, 8'h08, 1, 16'h0803};
    vecs[4] = '{1'b0, 2'd0, 8'hFF, 8'h01, 0, 16'h0100};
    vecs[5] = '{1'b1, 2'd3, 8'h77, 8'h00, 3, 16'hFFFF};
    vecs[6] = '{1'b0, 2'd2, 8'h10, 8'h10, 1, 16'h0100};
    vecs[7] = '{1'b1, 2'd1, 8'h55, 8'h55, 0, 16'h0000};

    rst = 1'b1;
    drive(0, 1, 2'd0, 8'h11, 8'h22);
    drive(1, 1, 2'd1, 8'h33, 8'h44);
    rsp_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_starts", starts, 4'd0);
    check("rst_ctrl", {rsp_valid, rsp_err, busy, rsp_id}, 4'd0);
    check("rst_ops", {au_a, au_b}, 16'd0);
    check("rst_rsp_data", {rsp_result, rsp_flags}, 20'd0);

    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    seq_pair();
    seq_full();
    seq_rst_wait();
    seq_timeout();
    seq_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
